// File: rtl/tx_share_arbiter.sv
// Round-robin sequencer sharing one serial byte transmitter between NREQ requesters.
// Optional WAIT_END watchdog enabled by defining TX_TIMEOUT_EN.
module tx_share_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned IDXW      = 3,
    parameter int unsigned TO_CYCLES = 2047
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*8-1:0] data_bus_i,
    input  logic              dsr_i,
    input  logic              tx_end_i,
    output logic              load_o,
    output logic              send_o,
    output logic [7:0]        out_data_o,
    output logic [IDXW-1:0]   chan_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              error_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StWaitEnd} state_e;

    state_e            state_q;
    logic [IDXW-1:0]   ptr_q;
    logic [IDXW-1:0]   chan_q;
    logic [7:0]        data_q;
    logic [NREQ-1:0]   grant_q;
    logic              load_q;
    logic              send_q;
    logic              busy_q;
    logic              error_q;

    logic              win_found;
    int unsigned       win_idx;
    logic [7:0]        win_data;
    logic [IDXW-1:0]   ptr_next;

`ifdef TX_TIMEOUT_EN
    logic [10:0]       cnt_q;
    logic              expired;
    assign expired = (cnt_q == 11'(TO_CYCLES - 1));
`endif

    // Scan ptr, ptr+1, ... mod NREQ and keep the first active request.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        win_data  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + i) % NREQ;
            if (!win_found && |(req_i & (NREQ'(1) << idx))) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (win_idx == j) win_data = data_bus_i[8*j +: 8];
        end
    end

    assign ptr_next = (chan_q == IDXW'(NREQ - 1)) ? '0 : chan_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            chan_q  <= '0;
            data_q  <= 8'h00;
            grant_q <= '0;
            load_q  <= 1'b0;
            send_q  <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef TX_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            grant_q <= '0;
            if (tx_end_i && state_q != StWaitEnd) error_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (dsr_i && win_found) begin
                        chan_q  <= IDXW'(win_idx);
                        data_q  <= win_data;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    load_q  <= 1'b0;
                    send_q  <= 1'b1;
                    state_q <= StSend;
                end
                StSend: begin
                    send_q  <= 1'b0;
                    state_q <= StWaitEnd;
`ifdef TX_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWaitEnd: begin
                    if (tx_end_i) begin
                        grant_q <= NREQ'(1) << chan_q;
                        error_q <= 1'b0;
                        ptr_q   <= ptr_next;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
`ifdef TX_TIMEOUT_EN
                    end else if (expired) begin
                        error_q <= 1'b1;
                        ptr_q   <= ptr_next;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q   <= cnt_q + 11'd1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign load_o     = load_q;
    assign send_o     = send_q;
    assign out_data_o = data_q;
    assign chan_o     = chan_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_tx_share_arbiter.sv
// Directed self-checking bench for tx_share_arbiter (NREQ=4, TO_CYCLES=16).
module tb_tx_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_bus;
    logic        dsr;
    logic        tx_end;
    logic        load;
    logic        send;
    logic [7:0]  out_data;
    logic [2:0]  chan;
    logic [3:0]  grant;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] byte_of [4] = '{8'h5A, 8'h3C, 8'hA5, 8'h77};

    tx_share_arbiter #(
        .NREQ      (4),
        .IDXW      (3),
        .TO_CYCLES (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .data_bus_i (data_bus),
        .dsr_i      (dsr),
        .tx_end_i   (tx_end),
        .load_o     (load),
        .send_o     (send),
        .out_data_o (out_data),
        .chan_o     (chan),
        .grant_o    (grant),
        .busy_o     (busy),
        .error_o    (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = '0; dsr = 1'b0; tx_end = 1'b0;
        data_bus = {byte_of[3], byte_of[2], byte_of[1], byte_of[0]};
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; dsr = 1'b0; tx_end = 1'b0; data_bus = '0;
        step();
        n_checks++;
        if ({load, send, out_data, chan, grant, busy, error} !== 17'h0)
            $display("FAIL reset_outputs: got %0h want 0",
                     {load, send, out_data, chan, grant, busy, error});
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        dsr = 1'b1; req = 4'b0100;
        step();
        n_checks++;
        if ({load, send, out_data, chan, busy} !== {1'b1, 1'b0, 8'hA5, 3'd2, 1'b1})
            $display("FAIL single_load: got %0h want %0h",
                     {load, send, out_data, chan, busy}, {1'b1, 1'b0, 8'hA5, 3'd2, 1'b1});
        else n_pass++;
        step();
        n_checks++;
        if ({load, send} !== 2'b01) $display("FAIL single_send: got %b want 01", {load, send});
        else n_pass++;
        step();
        n_checks++;
        if ({send, busy, grant} !== {1'b0, 1'b1, 4'b0000})
            $display("FAIL single_wait: got %b want 010000", {send, busy, grant});
        else n_pass++;
        tx_end = 1'b1;
        step();
        tx_end = 1'b0; req = '0;
        n_checks++;
        if ({grant, busy} !== {4'b0100, 1'b0})
            $display("FAIL single_grant: got %b want 01000", {grant, busy});
        else n_pass++;
        step();
        n_checks++;
        if ({grant, busy, load} !== 6'b0)
            $display("FAIL single_after: got %b want 000000", {grant, busy, load});
        else n_pass++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        dsr = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if ({load, chan, out_data} !== {1'b1, 3'(k % 4), byte_of[k % 4]})
                $display("FAIL rr_load%0d: got %0h want %0h", k, {load, chan, out_data},
                         {1'b1, 3'(k % 4), byte_of[k % 4]});
            else n_pass++;
            step();
            step();
            tx_end = 1'b1;
            step();
            tx_end = 1'b0;
            if (k == 4) req = '0;
            n_checks++;
            if (grant !== (4'b0001 << (k % 4)))
                $display("FAIL rr_grant%0d: got %b want %b", k, grant, 4'b0001 << (k % 4));
            else n_pass++;
        end
        step();
        n_checks++;
        if ({busy, load, grant} !== 6'b0)
            $display("FAIL rr_idle: got %b want 000000", {busy, load, grant});
        else n_pass++;
    endtask

    task automatic test_dsr_gate();
        int bad;
        apply_reset();
        dsr = 1'b0; req = 4'b0001; bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (load !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL dsr_low_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        dsr = 1'b1;
        step();
        n_checks++;
        if ({load, chan} !== {1'b1, 3'd0})
            $display("FAIL dsr_high_load: got %0h want 8", {load, chan});
        else n_pass++;
        step();
        step();
        tx_end = 1'b1;
        step();
        tx_end = 1'b0; req = '0;
        n_checks++;
        if (grant !== 4'b0001) $display("FAIL dsr_grant: got %b want 0001", grant);
        else n_pass++;
        step();
    endtask

    task automatic test_error();
        apply_reset();
        dsr = 1'b1; req = '0; tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        n_checks++;
        if ({error, grant} !== 5'b10000)
            $display("FAIL err_set: got %b want 10000", {error, grant});
        else n_pass++;
        step();
        n_checks++;
        if (error !== 1'b1) $display("FAIL err_sticky: got %b want 1", error);
        else n_pass++;
        req = 4'b0010;
        step();
        n_checks++;
        if ({load, chan, out_data, error} !== {1'b1, 3'd1, 8'h3C, 1'b1})
            $display("FAIL err_load: got %0h want %0h", {load, chan, out_data, error},
                     {1'b1, 3'd1, 8'h3C, 1'b1});
        else n_pass++;
        step();
        step();
        tx_end = 1'b1;
        step();
        tx_end = 1'b0; req = '0;
        n_checks++;
        if ({grant, error} !== 5'b00100)
            $display("FAIL err_clear: got %b want 00100", {grant, error});
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        dsr = 1'b1; req = 4'b0100;
        step();
        step();
        step();
        tx_end = 1'b1;
        step();
        tx_end = 1'b0; req = 4'b1010;
        step();
        n_checks++;
        if ({load, chan} !== {1'b1, 3'd3})
            $display("FAIL mid_ptr3: got %0h want b", {load, chan});
        else n_pass++;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({load, send, out_data, chan, grant, busy, error} !== 17'h0)
            $display("FAIL mid_async_clear: got %0h want 0",
                     {load, send, out_data, chan, grant, busy, error});
        else n_pass++;
        step();
        n_checks++;
        if ({grant, busy} !== 5'b0) $display("FAIL mid_no_grant: got %b want 00000", {grant, busy});
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if ({load, chan, out_data} !== {1'b1, 3'd1, 8'h3C})
            $display("FAIL mid_restart: got %0h want %0h", {load, chan, out_data},
                     {1'b1, 3'd1, 8'h3C});
        else n_pass++;
        step();
        step();
        tx_end = 1'b1;
        step();
        tx_end = 1'b0; req = '0;
        n_checks++;
        if (grant !== 4'b0010) $display("FAIL mid_grant: got %b want 0010", grant);
        else n_pass++;
        step();
    endtask

`ifdef TX_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        dsr = 1'b1; req = 4'b0010;
        step();
        step();
        step();
        req = '0;
        repeat (15) step();
        n_checks++;
        if ({busy, error} !== 2'b10) $display("FAIL to_before: got %b want 10", {busy, error});
        else n_pass++;
        step();
        n_checks++;
        if ({busy, error, grant} !== 6'b010000)
            $display("FAIL to_expire: got %b want 010000", {busy, error, grant});
        else n_pass++;
        step();
        n_checks++;
        if (grant !== 4'b0000) $display("FAIL to_no_grant: got %b want 0000", grant);
        else n_pass++;
        req = 4'b0101;
        step();
        n_checks++;
        if ({load, chan} !== {1'b1, 3'd2})
            $display("FAIL to_ptr: got %0h want a", {load, chan});
        else n_pass++;
        step();
        step();
        req = '0;
        repeat (15) step();
        tx_end = 1'b1;
        step();
        tx_end = 1'b0;
        n_checks++;
        if ({grant, error, busy} !== 6'b010000)
            $display("FAIL to_tx_end_wins: got %b want 010000", {grant, error, busy});
        else n_pass++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_dsr_gate();
        test_error();
        test_reset_mid();
`ifdef TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
